board_io_ctrl: RTL and testbench
================================

BOARD_IO_CTRL -- requirements
Module: board_io_ctrl

Interface
REQ-001 SHALL have parameter NUM_BTN, default 5, number of push-button inputs.
REQ-002 SHALL have parameter NUM_SW, default 16, number of slide-switch inputs.
REQ-003 SHALL have parameter NUM_LED, default 16, number of LED outputs.
REQ-004 SHALL have parameter SYNC_STAGES, default 2 (min 2), synchronizer flop depth.
REQ-005 SHALL have parameter DEBOUNCE_CYCLES, default 1000000 (min 2), stable cycles required before a button level is accepted.
REQ-006 SHALL have parameter RST_STRETCH, default 16 (min 1), cycles that sys_rst_o is held after lock.
REQ-007 SHALL have parameter PWM_W, default 4, LED brightness width.
REQ-008 clk_i  in  1  single system clock; all logic on its rising edge.
REQ-009 arst_n_i  in  1  asynchronous active-low reset.
REQ-010 pll_locked_i  in  1  PLL lock, asynchronous to clk_i.
REQ-011 btn_i  in  NUM_BTN  raw buttons, active high, asynchronous.
REQ-012 sw_i  in  NUM_SW  raw switches, asynchronous.
REQ-013 led_i  in  NUM_LED  LED request from core.
REQ-014 led_bright_i  in  PWM_W  LED brightness.
REQ-015 irq_mask_i  in  NUM_BTN  per-button irq enable.
REQ-016 irq_ack_i  in  1  single-cycle irq clear.
REQ-017 sys_rst_o  out  1  active-high core reset.
REQ-018 sw_o  out  NUM_SW  synchronized switches.
REQ-019 btn_level_o  out  NUM_BTN  debounced button level.
REQ-020 btn_press_o  out  NUM_BTN  one-cycle pulse per debounced rise.
REQ-021 irq_o  out  1  sticky button interrupt.
REQ-022 led_o  out  NUM_LED  PWM-gated LEDs.

Function
REQ-023 pll_locked_i, btn_i, sw_i SHALL each pass through a SYNC_STAGES flop chain; sw_o = last stage (latency SYNC_STAGES cycles).
REQ-024 Reset sequencer SHALL be an FSM with states HOLD, STRETCH, RUN; sys_rst_o = 1 in HOLD and STRETCH, 0 in RUN, registered.
REQ-025 HOLD -> STRETCH when synchronized lock = 1; counter cleared on entry.
REQ-026 STRETCH -> RUN when counter reaches RST_STRETCH-1; otherwise counter increments.
REQ-027 From STRETCH or RUN, synchronized lock = 0 SHALL force HOLD next cycle; sys_rst_o re-asserts that same edge.
REQ-028 Each button SHALL have an independent counter of width clog2(DEBOUNCE_CYCLES): synced input == level -> counter cleared; differs -> counter increments; at DEBOUNCE_CYCLES-1 with input still differing, level takes input and counter clears.
REQ-029 A glitch shorter than DEBOUNCE_CYCLES SHALL leave btn_level_o unchanged.
REQ-030 btn_press_o[i] SHALL be 1 for exactly the cycle after btn_level_o[i] goes 0->1; no pulse on 1->0.
REQ-031 irq_o SHALL set the cycle after any btn_press_o[i] & irq_mask_i[i]; clear the cycle after irq_ack_i; simultaneous set and ack -> stays 1 (set wins).
REQ-032 A free-running PWM_W-bit counter SHALL wrap from all-ones to 0.
REQ-033 led_o[j] = led_i[j] & (led_bright_i == all-ones | pwm_cnt < led_bright_i); registered, 1 cycle latency; led_bright_i = 0 -> all LEDs off.
REQ-034 Debounce, sync, irq and PWM logic SHALL run independent of sys_rst_o (reset only by arst_n_i).

Reset
REQ-035 arst_n_i low SHALL asynchronously force: FSM = HOLD, sys_rst_o = 1, all sync flops, counters, btn_level_o, btn_press_o, irq_o, sw_o, led_o = 0.
REQ-036 arst_n_i deassertion SHALL be synchronous to clk_i via a SYNC_STAGES reset synchronizer; sys_rst_o stays 1 until RUN.
REQ-037 arst_n_i asserted mid-STRETCH or mid-debounce SHALL discard progress; restart from HOLD / zero counts.

Verification (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, RST_STRETCH=8, PWM_W=4)
REQ-038 Release reset, lock=1 constant -> sys_rst_o falls exactly once, 8 cycles after FSM leaves HOLD; drop lock for 1 cycle in RUN -> sys_rst_o re-asserts, then deasserts after 8 more cycles.
REQ-039 btn_i[0] high 3 cycles then low -> no btn_level_o/btn_press_o change; high 10 cycles -> btn_level_o[0] = 1 and exactly one btn_press_o[0] pulse.
REQ-040 irq_mask_i = 5'b00001; press btn 1 -> irq_o stays 0; press btn 0 -> irq_o = 1; irq_ack_i in the same cycle as a new masked press -> irq_o stays 1.
REQ-041 led_i = 16'hFFFF, led_bright_i = 4 -> each LED high 4 of every 16 cycles; bright = 15 -> constantly high; bright = 0 -> constantly low.
REQ-042 sw_i = 16'hA5A5 -> sw_o = 16'hA5A5 exactly 2 cycles later.
REQ-043 Assert arst_n_i during STRETCH with button count 2 -> all outputs reset, sys_rst_o = 1, full 8-cycle stretch repeated after release.

Source files
------------

// File: rtl/board_io_if.sv
// Board-side I/O bundle for board_io_ctrl: PLL lock, buttons, switches,
// LEDs and the button interrupt handshake toward the core.
interface board_io_if #(
    parameter int NUM_BTN = 5,
    parameter int NUM_SW  = 16,
    parameter int NUM_LED = 16,
    parameter int PWM_W   = 4
);
    logic               pll_locked_i;
    logic [NUM_BTN-1:0] btn_i;
    logic [NUM_SW-1:0]  sw_i;
    logic [NUM_LED-1:0] led_i;
    logic [PWM_W-1:0]   led_bright_i;
    logic [NUM_BTN-1:0] irq_mask_i;
    logic               irq_ack_i;
    logic               sys_rst_o;
    logic [NUM_SW-1:0]  sw_o;
    logic [NUM_BTN-1:0] btn_level_o;
    logic [NUM_BTN-1:0] btn_press_o;
    logic               irq_o;
    logic [NUM_LED-1:0] led_o;

    // Board/core side: drives raw inputs and requests, observes results.
    modport master (
        output pll_locked_i, btn_i, sw_i, led_i, led_bright_i, irq_mask_i, irq_ack_i,
        input  sys_rst_o, sw_o, btn_level_o, btn_press_o, irq_o, led_o
    );

    // Controller side.
    modport slave (
        input  pll_locked_i, btn_i, sw_i, led_i, led_bright_i, irq_mask_i, irq_ack_i,
        output sys_rst_o, sw_o, btn_level_o, btn_press_o, irq_o, led_o
    );
endinterface

// File: rtl/board_io_ctrl.sv
// Board I/O controller: reset synchronizer, PLL-lock driven core reset
// sequencer, input synchronizers, button debounce/press/irq and LED PWM.
//
// Reset sequencer states:
//   state   | meaning
//   HOLD    | PLL not locked, core held in reset
//   STRETCH | lock seen, counting RST_STRETCH cycles before release
//   RUN     | core out of reset, lock monitored
module board_io_ctrl #(
    parameter int NUM_BTN         = 5,
    parameter int NUM_SW          = 16,
    parameter int NUM_LED         = 16,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int RST_STRETCH     = 16,
    parameter int PWM_W           = 4
) (
    input  logic       clk_i,
    input  logic       arst_n_i,
    board_io_if.slave  io
);

    localparam int SYNC_BITS = 1 + NUM_BTN + NUM_SW;
    localparam int DBW       = $clog2(DEBOUNCE_CYCLES);
    localparam int SCW       = (RST_STRETCH > 1) ? $clog2(RST_STRETCH) : 1;
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [SCW-1:0] ST_LAST = SCW'(RST_STRETCH - 1);

    typedef enum logic [1:0] {HOLD, STRETCH, RUN} rst_state_t;

    logic [SYNC_STAGES-1:0]                rst_chain;
    logic                                  rst_n;
    logic [SYNC_STAGES-1:0][SYNC_BITS-1:0] sync_q;
    logic                                  lock_s;
    logic [NUM_BTN-1:0]                    btn_s;
    rst_state_t                            state;
    logic [SCW-1:0]                        str_cnt;
    logic                                  sys_rst;
    logic [NUM_BTN-1:0][DBW-1:0]           db_cnt;
    logic [NUM_BTN-1:0]                    btn_level;
    logic [NUM_BTN-1:0]                    btn_press;
    logic                                  irq;
    logic [PWM_W-1:0]                      pwm_cnt;
    logic [NUM_LED-1:0]                    led;

    // Reset asserts immediately but releases only after SYNC_STAGES clean edges.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) rst_chain <= '0;
        else           rst_chain <= {rst_chain[SYNC_STAGES-2:0], 1'b1};
    end

    assign rst_n = rst_chain[SYNC_STAGES-1];

    // One shared synchronizer chain for lock, buttons and switches.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= {io.sw_i, io.btn_i, io.pll_locked_i};
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    assign lock_s = sync_q[SYNC_STAGES-1][0];
    assign btn_s  = sync_q[SYNC_STAGES-1][NUM_BTN:1];

    // Core reset sequencer; loss of lock always drops straight back to HOLD.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state   <= HOLD;
            str_cnt <= '0;
            sys_rst <= 1'b1;
        end else begin
            case (state)
                HOLD: begin
                    sys_rst <= 1'b1;
                    if (lock_s) begin
                        state   <= STRETCH;
                        str_cnt <= '0;
                    end
                end
                STRETCH: begin
                    if (!lock_s) begin
                        state   <= HOLD;
                        sys_rst <= 1'b1;
                    end else if (str_cnt == ST_LAST) begin
                        state   <= RUN;
                        sys_rst <= 1'b0;
                    end else begin
                        str_cnt <= str_cnt + SCW'(1);
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state   <= HOLD;
                        sys_rst <= 1'b1;
                    end
                end
                default: begin
                    state   <= HOLD;
                    sys_rst <= 1'b1;
                end
            endcase
        end
    end

    // Per-button debounce; press pulses in the first cycle the new high level shows.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt    <= '0;
            btn_level <= '0;
            btn_press <= '0;
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                btn_press[i] <= 1'b0;
                if (btn_s[i] == btn_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    btn_level[i] <= btn_s[i];
                    btn_press[i] <= btn_s[i];
                    db_cnt[i]    <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DBW'(1);
                end
            end
        end
    end

    // Sticky interrupt; a new masked press beats a simultaneous ack.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n)                        irq <= 1'b0;
        else if (|(btn_press & io.irq_mask_i)) irq <= 1'b1;
        else if (io.irq_ack_i)             irq <= 1'b0;
    end

    // Free-running PWM ramp and registered LED gating; full scale bypasses the compare.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
            led     <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_W'(1);
            led     <= io.led_i & {NUM_LED{(io.led_bright_i == '1) || (pwm_cnt < io.led_bright_i)}};
        end
    end

    assign io.sys_rst_o   = sys_rst;
    assign io.sw_o        = sync_q[SYNC_STAGES-1][SYNC_BITS-1:NUM_BTN+1];
    assign io.btn_level_o = btn_level;
    assign io.btn_press_o = btn_press;
    assign io.irq_o       = irq;
    assign io.led_o       = led;

endmodule

// File: tb/tb_board_io_ctrl.sv
// Testbench for board_io_ctrl: directed reset/debounce/irq/LED/switch steps
// plus a randomized section, with a cycle-level behavioural model of the
// switch, button and interrupt outputs.
module tb_board_io_ctrl;
    localparam int NB = 5;
    localparam int NS = 16;
    localparam int NL = 16;
    localparam int SS = 2;
    localparam int DB = 4;
    localparam int RS = 8;
    localparam int PW = 4;

    logic clk_i = 1'b0;
    logic arst_n_i;

    always #5 clk_i = ~clk_i;

    board_io_if #(.NUM_BTN(NB), .NUM_SW(NS), .NUM_LED(NL), .PWM_W(PW)) bus ();

    board_io_ctrl #(
        .NUM_BTN(NB), .NUM_SW(NS), .NUM_LED(NL), .SYNC_STAGES(SS),
        .DEBOUNCE_CYCLES(DB), .RST_STRETCH(RS), .PWM_W(PW)
    ) dut (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .io       (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // model state
    logic [NB-1:0] btn_hist[$];
    logic [NS-1:0] sw_hist[$];
    logic [NB-1:0] m_level, m_press;
    logic          m_irq;
    logic [NS-1:0] m_sw;
    int            rel_cnt;
    bit            mdl_chk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NB-1:0] bh(input int idx);
        if (idx < btn_hist.size()) return btn_hist[idx];
        return '0;
    endfunction

    function automatic logic [NS-1:0] sh(input int idx);
        if (idx < sw_hist.size()) return sw_hist[idx];
        return '0;
    endfunction

    // Model: inputs reach the logic SYNC edges late; a button level flips once
    // the synchronized value has disagreed with it for DB consecutive edges.
    task automatic model_edge();
        logic [NB-1:0] prev_press;
        logic [NB-1:0] w;
        logic          v;
        bit            same;
        if (!arst_n_i) begin
            btn_hist.delete();
            sw_hist.delete();
            m_level = '0; m_press = '0; m_irq = 1'b0; m_sw = '0;
            rel_cnt = 0;
        end else if (rel_cnt < SS) begin
            rel_cnt++;
        end else begin
            prev_press = m_press;
            btn_hist.push_front(bus.btn_i);
            sw_hist.push_front(bus.sw_i);
            while (btn_hist.size() > SS + DB) void'(btn_hist.pop_back());
            while (sw_hist.size() > SS) void'(sw_hist.pop_back());
            m_sw    = sh(SS - 1);
            m_press = '0;
            for (int i = 0; i < NB; i++) begin
                w    = bh(SS);
                v    = w[i];
                same = 1'b1;
                for (int j = 1; j < DB; j++) begin
                    w = bh(SS + j);
                    if (w[i] != v) same = 1'b0;
                end
                if (same && (v != m_level[i])) begin
                    m_level[i] = v;
                    m_press[i] = v;
                end
            end
            if (|(prev_press & bus.irq_mask_i)) m_irq = 1'b1;
            else if (bus.irq_ack_i)             m_irq = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        model_edge();
        @(negedge clk_i);
        if (mdl_chk) begin
            check("sw_o",        64'(bus.sw_o),        64'(m_sw));
            check("btn_level_o", 64'(bus.btn_level_o), 64'(m_level));
            check("btn_press_o", 64'(bus.btn_press_o), 64'(m_press));
            check("irq_o",       64'(bus.irq_o),       64'(m_irq));
        end
    endtask

    initial begin
        int fall_at, rise_at, falls, rises, np, nl, cnt;
        bit prev, uni, found, any_irq;
        logic [PW-1:0] brights[4];

        mdl_chk = 1'b0;
        arst_n_i = 1'b0;
        bus.pll_locked_i = 1'b1;
        bus.btn_i = '1;
        bus.sw_i = 16'hFFFF;
        bus.led_i = 16'hFFFF;
        bus.led_bright_i = 4'hF;
        bus.irq_mask_i = '1;
        bus.irq_ack_i = 1'b0;
        repeat (3) step();

        check("rst_sys_rst", 64'(bus.sys_rst_o),   64'd1);
        check("rst_sw_o",    64'(bus.sw_o),        64'd0);
        check("rst_level",   64'(bus.btn_level_o), 64'd0);
        check("rst_press",   64'(bus.btn_press_o), 64'd0);
        check("rst_irq",     64'(bus.irq_o),       64'd0);
        check("rst_led",     64'(bus.led_o),       64'd0);

        bus.btn_i = '0;
        bus.sw_i = '0;
        bus.irq_mask_i = '0;
        mdl_chk = 1'b1;

        // reset release with lock held high
        arst_n_i = 1'b1;
        fall_at = 0; falls = 0; rises = 0; prev = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            step();
            if (prev && !bus.sys_rst_o) begin falls++; if (fall_at == 0) fall_at = k; end
            if (!prev && bus.sys_rst_o) rises++;
            prev = bus.sys_rst_o;
        end
        check("rst_fall_cycle", 64'(fall_at), 64'(2*SS + 1 + RS));
        check("rst_fall_count", 64'(falls), 64'd1);
        check("rst_rise_count", 64'(rises), 64'd0);

        // one-cycle lock drop while running
        rise_at = 0; fall_at = 0; prev = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 1) bus.pll_locked_i = 1'b0;
            step();
            bus.pll_locked_i = 1'b1;
            if (!prev && bus.sys_rst_o && rise_at == 0) rise_at = k;
            if (prev && !bus.sys_rst_o && fall_at == 0) fall_at = k;
            prev = bus.sys_rst_o;
        end
        check("lock_drop_rise", 64'(rise_at), 64'(SS + 1));
        check("lock_drop_fall", 64'(fall_at), 64'(SS + 2 + RS));

        // switch latency
        bus.sw_i = 16'h1234;
        step(); step();
        bus.sw_i = 16'hA5A5;
        step();
        check("sw_lat1", 64'(bus.sw_o), 64'h1234);
        step();
        check("sw_lat2", 64'(bus.sw_o), 64'hA5A5);

        // short glitch on button 0
        np = 0; nl = 0;
        bus.btn_i = 5'b00001;
        repeat (3) step();
        bus.btn_i = '0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (bus.btn_press_o[0]) np++;
            if (bus.btn_level_o[0]) nl++;
        end
        check("glitch_press", 64'(np), 64'd0);
        check("glitch_level", 64'(nl), 64'd0);

        // long press on button 0
        np = 0;
        bus.btn_i = 5'b00001;
        for (int k = 0; k < 10; k++) begin
            step();
            if (bus.btn_press_o[0]) np++;
        end
        check("long_level", 64'(bus.btn_level_o[0]), 64'd1);
        check("long_press_cnt", 64'(np), 64'd1);
        np = 0;
        bus.btn_i = '0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (bus.btn_press_o[0]) np++;
        end
        check("release_press_cnt", 64'(np), 64'd0);
        check("release_level", 64'(bus.btn_level_o[0]), 64'd0);

        // interrupt masking, ack, and set-over-ack
        bus.irq_mask_i = 5'b00001;
        any_irq = 1'b0;
        bus.btn_i = 5'b00010;
        for (int k = 0; k < 10; k++) begin step(); if (bus.irq_o) any_irq = 1'b1; end
        bus.btn_i = '0;
        for (int k = 0; k < 10; k++) begin step(); if (bus.irq_o) any_irq = 1'b1; end
        check("irq_masked_btn1", 64'(any_irq), 64'd0);
        bus.btn_i = 5'b00001;
        repeat (10) step();
        check("irq_btn0", 64'(bus.irq_o), 64'd1);
        bus.btn_i = '0;
        repeat (10) step();
        check("irq_sticky", 64'(bus.irq_o), 64'd1);
        bus.irq_ack_i = 1'b1;
        step();
        bus.irq_ack_i = 1'b0;
        check("irq_ack_clear", 64'(bus.irq_o), 64'd0);
        bus.btn_i = 5'b00001;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            if (m_press[0]) found = 1'b1;
        end
        check("press_wait", 64'(found), 64'd1);
        bus.irq_ack_i = 1'b1;
        step();
        bus.irq_ack_i = 1'b0;
        check("irq_set_wins", 64'(bus.irq_o), 64'd1);
        bus.btn_i = '0;
        bus.irq_ack_i = 1'b1;
        step();
        bus.irq_ack_i = 1'b0;
        repeat (10) step();

        // LED PWM duty
        bus.led_i = 16'hFFFF;
        brights[0] = 4'd4; brights[1] = 4'd15; brights[2] = 4'd0; brights[3] = 4'd9;
        for (int b = 0; b < 4; b++) begin
            bus.led_bright_i = brights[b];
            step(); step();
            cnt = 0; uni = 1'b1;
            for (int k = 0; k < 16; k++) begin
                step();
                if (bus.led_o[0]) cnt++;
                if (bus.led_o != 16'h0000 && bus.led_o != 16'hFFFF) uni = 1'b0;
            end
            check($sformatf("led_duty_b%0d", brights[b]), 64'(cnt),
                  (brights[b] == 4'd15) ? 64'd16 : 64'(brights[b]));
            check($sformatf("led_uniform_b%0d", brights[b]), 64'(uni), 64'd1);
        end
        bus.led_i = 16'h00F0;
        bus.led_bright_i = 4'd15;
        step();
        check("led_pattern", 64'(bus.led_o), 64'h00F0);

        // randomized switches, buttons, mask and ack against the model
        for (int k = 0; k < 400; k++) begin
            bus.sw_i = 16'($urandom);
            for (int i = 0; i < NB; i++)
                if ($urandom_range(0, 4) == 0) bus.btn_i[i] = ~bus.btn_i[i];
            if (k % 50 == 0) bus.irq_mask_i = 5'($urandom);
            bus.irq_ack_i = ($urandom_range(0, 7) == 0);
            step();
        end
        bus.irq_ack_i = 1'b0;
        bus.btn_i = '0;
        repeat (12) step();

        // async reset mid-stretch with a debounce count in progress
        bus.pll_locked_i = 1'b0;
        repeat (3) step();
        bus.pll_locked_i = 1'b1;
        bus.btn_i = 5'b00001;
        repeat (4) step();
        check("pre_arst_in_stretch", 64'(bus.sys_rst_o), 64'd1);
        arst_n_i = 1'b0;
        #1;
        check("arst_sys_rst", 64'(bus.sys_rst_o),   64'd1);
        check("arst_sw_o",    64'(bus.sw_o),        64'd0);
        check("arst_level",   64'(bus.btn_level_o), 64'd0);
        check("arst_irq",     64'(bus.irq_o),       64'd0);
        check("arst_led",     64'(bus.led_o),       64'd0);
        repeat (2) step();
        arst_n_i = 1'b1;
        fall_at = 0; falls = 0; prev = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            step();
            if (prev && !bus.sys_rst_o) begin falls++; if (fall_at == 0) fall_at = k; end
            prev = bus.sys_rst_o;
        end
        check("restretch_fall_cycle", 64'(fall_at), 64'(2*SS + 1 + RS));
        check("restretch_fall_count", 64'(falls), 64'd1);
        check("restart_level", 64'(bus.btn_level_o[0]), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
